// File: rtl/fu_bank_pkg.sv
// Shared definitions for the execution-unit bank: op encodings, unit indices,
// MEM sequencer states and the completion bundle.
package fu_bank_pkg;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned TAG_W_MAX = 16;
  localparam int unsigned NUM_FU    = 3;
  localparam int unsigned SHAMT_W   = 5;

  localparam int unsigned FU_ALU0 = 0;
  localparam int unsigned FU_ALU1 = 1;
  localparam int unsigned FU_MEM  = 2;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_XOR = 3'd4,
    OP_SLL = 3'd5,
    OP_SRL = 3'd6,
    OP_SLT = 3'd7
  } alu_op_e;

  typedef enum logic [1:0] {
    MEM_IDLE = 2'd0,
    MEM_REQ  = 2'd1,
    MEM_WAIT = 2'd2,
    MEM_DONE = 2'd3
  } mem_state_e;

  // Tags are carried at maximum width and narrowed at the top-level ports.
  typedef struct packed {
    logic                 valid;
    logic                 we;
    logic [TAG_W_MAX-1:0] rd;
    logic [TAG_W_MAX-1:0] rob;
    logic [XLEN-1:0]      data;
  } cmp_t;

endpackage

// File: rtl/fu_alu.sv
// Combinational integer ALU: decodes the 3-bit op and produces a 32-bit result.
module fu_alu
  import fu_bank_pkg::*;
(
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] res_c
);

  logic [SHAMT_W-1:0] shamt;

  assign shamt = b[SHAMT_W-1:0];

  always_comb begin
    res_c = '0;
    unique case (alu_op_e'(op))
      OP_ADD: res_c = a + b;
      OP_SUB: res_c = a - b;
      OP_AND: res_c = a & b;
      OP_OR:  res_c = a | b;
      OP_XOR: res_c = a ^ b;
      OP_SLL: res_c = a << shamt;
      OP_SRL: res_c = a >> shamt;
      OP_SLT: res_c = XLEN'($signed(a) < $signed(b));
      default: res_c = '0;
    endcase
  end

endmodule

// File: rtl/fu_bank.sv
// Execution bank behind the reservation station: two single-entry ALUs, one
// MEM sequencer on a req/gnt/rvalid port, and a fixed-priority completion bus.
module fu_bank
  import fu_bank_pkg::*;
#(
  parameter int unsigned PREG_WIDTH = 6,
  parameter int unsigned ROB_WIDTH  = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,

  input  logic [NUM_FU-1:0]     iss_valid,
  input  logic [2:0]            iss_op_0,
  input  logic [2:0]            iss_op_1,
  input  logic [2:0]            iss_op_2,
  input  logic [XLEN-1:0]       iss_a_0,
  input  logic [XLEN-1:0]       iss_a_1,
  input  logic [XLEN-1:0]       iss_a_2,
  input  logic [XLEN-1:0]       iss_b_0,
  input  logic [XLEN-1:0]       iss_b_1,
  input  logic [XLEN-1:0]       iss_b_2,
  input  logic [XLEN-1:0]       iss_sd_2,
  input  logic [PREG_WIDTH-1:0] iss_rd_0,
  input  logic [PREG_WIDTH-1:0] iss_rd_1,
  input  logic [PREG_WIDTH-1:0] iss_rd_2,
  input  logic [ROB_WIDTH-1:0]  iss_rob_0,
  input  logic [ROB_WIDTH-1:0]  iss_rob_1,
  input  logic [ROB_WIDTH-1:0]  iss_rob_2,

  output logic [NUM_FU-1:0]     fu_ready,

  output logic                  mem_req,
  output logic                  mem_we,
  output logic [XLEN-1:0]       mem_addr,
  output logic [XLEN-1:0]       mem_wdata,
  input  logic                  mem_gnt,
  input  logic                  mem_rvalid,
  input  logic [XLEN-1:0]       mem_rdata,

  output logic                  cmp_valid,
  output logic                  cmp_we,
  output logic [PREG_WIDTH-1:0] cmp_rd,
  output logic [ROB_WIDTH-1:0]  cmp_rob,
  output logic [XLEN-1:0]       cmp_data
);

  logic [XLEN-1:0] alu0_res_c;
  logic [XLEN-1:0] alu1_res_c;

  cmp_t       alu0_q, alu0_d;
  cmp_t       alu1_q, alu1_d;
  cmp_t       mem_q,  mem_d;
  mem_state_e state_q, state_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;

  cmp_t              cmp_sel_c;
  logic              sel_mem_c, sel_alu0_c, sel_alu1_c;
  logic [NUM_FU-1:0] accept_c;
  logic              unused_op_bits;

  // Only bit0 of the MEM op is meaningful (load/store).
  assign unused_op_bits = ^iss_op_2[2:1];

  fu_alu u_alu0 (
    .op    (iss_op_0),
    .a     (iss_a_0),
    .b     (iss_b_0),
    .res_c (alu0_res_c)
  );

  fu_alu u_alu1 (
    .op    (iss_op_1),
    .a     (iss_a_1),
    .b     (iss_b_1),
    .res_c (alu1_res_c)
  );

  // Completion select: MEM(DONE) > ALU0 > ALU1, built from held state only.
  always_comb begin
    sel_mem_c  = 1'b0;
    sel_alu0_c = 1'b0;
    sel_alu1_c = 1'b0;
    cmp_sel_c  = '0;
    if (state_q == MEM_DONE) begin
      sel_mem_c       = 1'b1;
      cmp_sel_c       = mem_q;
      cmp_sel_c.valid = 1'b1;
    end else if (alu0_q.valid) begin
      sel_alu0_c = 1'b1;
      cmp_sel_c  = alu0_q;
    end else if (alu1_q.valid) begin
      sel_alu1_c = 1'b1;
      cmp_sel_c  = alu1_q;
    end
  end

  assign fu_ready[FU_ALU0] = !alu0_q.valid || sel_alu0_c;
  assign fu_ready[FU_ALU1] = !alu1_q.valid || sel_alu1_c;
  assign fu_ready[FU_MEM]  = (state_q == MEM_IDLE);
  assign accept_c          = iss_valid & fu_ready;

  // ALU result registers: refill on accepted issue, otherwise drain when broadcast.
  always_comb begin
    alu0_d = alu0_q;
    alu1_d = alu1_q;
    if (accept_c[FU_ALU0]) begin
      alu0_d.valid = 1'b1;
      alu0_d.we    = 1'b1;
      alu0_d.rd    = TAG_W_MAX'(iss_rd_0);
      alu0_d.rob   = TAG_W_MAX'(iss_rob_0);
      alu0_d.data  = alu0_res_c;
    end else if (sel_alu0_c) begin
      alu0_d.valid = 1'b0;
    end
    if (accept_c[FU_ALU1]) begin
      alu1_d.valid = 1'b1;
      alu1_d.we    = 1'b1;
      alu1_d.rd    = TAG_W_MAX'(iss_rd_1);
      alu1_d.rob   = TAG_W_MAX'(iss_rob_1);
      alu1_d.data  = alu1_res_c;
    end else if (sel_alu1_c) begin
      alu1_d.valid = 1'b0;
    end
  end

  // MEM sequencer next-state and payload capture.
  always_comb begin
    state_d = state_q;
    mem_d   = mem_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    unique case (state_q)
      MEM_IDLE: begin
        if (accept_c[FU_MEM]) begin
          addr_d     = iss_a_2 + iss_b_2;
          wdata_d    = iss_sd_2;
          mem_d.we   = !iss_op_2[0];
          mem_d.rd   = TAG_W_MAX'(iss_rd_2);
          mem_d.rob  = TAG_W_MAX'(iss_rob_2);
          mem_d.data = '0;
          state_d    = MEM_REQ;
        end
      end
      MEM_REQ: begin
        if (mem_gnt) state_d = MEM_WAIT;
      end
      MEM_WAIT: begin
        if (mem_rvalid) begin
          mem_d.data = mem_d.we ? mem_rdata : '0;
          state_d    = MEM_DONE;
        end
      end
      MEM_DONE: begin
        if (sel_mem_c) state_d = MEM_IDLE;
      end
      default: state_d = MEM_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu0_q  <= '0;
      alu1_q  <= '0;
      mem_q   <= '0;
      state_q <= MEM_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      alu0_q  <= alu0_d;
      alu1_q  <= alu1_d;
      mem_q   <= mem_d;
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  // mem_we is derived from the load/store flag held in the MEM payload.
  assign mem_req   = (state_q == MEM_REQ);
  assign mem_we    = (state_q != MEM_IDLE) && !mem_q.we;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

  assign cmp_valid = cmp_sel_c.valid;
  assign cmp_we    = cmp_sel_c.we;
  assign cmp_rd    = PREG_WIDTH'(cmp_sel_c.rd);
  assign cmp_rob   = ROB_WIDTH'(cmp_sel_c.rob);
  assign cmp_data  = cmp_sel_c.data;

endmodule

// File: tb/tb_fu_bank.sv
// Directed self-checking bench for fu_bank: ALU ops, arbitration, MEM load/store
// handshakes and reset abandonment of an outstanding MEM operation.
module tb_fu_bank;

  logic        clk;
  logic        rst_n;
  logic [2:0]  iss_valid;
  logic [2:0]  iss_op_0, iss_op_1, iss_op_2;
  logic [31:0] iss_a_0, iss_a_1, iss_a_2;
  logic [31:0] iss_b_0, iss_b_1, iss_b_2;
  logic [31:0] iss_sd_2;
  logic [5:0]  iss_rd_0, iss_rd_1, iss_rd_2;
  logic [5:0]  iss_rob_0, iss_rob_1, iss_rob_2;
  logic [2:0]  fu_ready;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_gnt, mem_rvalid;
  logic [31:0] mem_rdata;
  logic        cmp_valid, cmp_we;
  logic [5:0]  cmp_rd, cmp_rob;
  logic [31:0] cmp_data;

  int n_checks;
  int n_errors;

  fu_bank #(.PREG_WIDTH(6), .ROB_WIDTH(6)) dut (
    .clk(clk), .rst_n(rst_n),
    .iss_valid(iss_valid),
    .iss_op_0(iss_op_0), .iss_op_1(iss_op_1), .iss_op_2(iss_op_2),
    .iss_a_0(iss_a_0), .iss_a_1(iss_a_1), .iss_a_2(iss_a_2),
    .iss_b_0(iss_b_0), .iss_b_1(iss_b_1), .iss_b_2(iss_b_2),
    .iss_sd_2(iss_sd_2),
    .iss_rd_0(iss_rd_0), .iss_rd_1(iss_rd_1), .iss_rd_2(iss_rd_2),
    .iss_rob_0(iss_rob_0), .iss_rob_1(iss_rob_1), .iss_rob_2(iss_rob_2),
    .fu_ready(fu_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .cmp_valid(cmp_valid), .cmp_we(cmp_we), .cmp_rd(cmp_rd), .cmp_rob(cmp_rob),
    .cmp_data(cmp_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    iss_valid  = '0;
    iss_op_0 = '0; iss_op_1 = '0; iss_op_2 = '0;
    iss_a_0 = '0; iss_a_1 = '0; iss_a_2 = '0;
    iss_b_0 = '0; iss_b_1 = '0; iss_b_2 = '0;
    iss_sd_2 = '0;
    iss_rd_0 = '0; iss_rd_1 = '0; iss_rd_2 = '0;
    iss_rob_0 = '0; iss_rob_1 = '0; iss_rob_2 = '0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
  endtask

  // ALU1 op vectors: op, a, b, expected result.
  logic [2:0]  v_op [7];
  logic [31:0] v_a  [7];
  logic [31:0] v_b  [7];
  logic [31:0] v_r  [7];

  initial begin
    v_op[0] = 3'd2; v_a[0] = 32'hF0F0_1234; v_b[0] = 32'h0FF0_FF00; v_r[0] = 32'h00F0_1200;
    v_op[1] = 3'd3; v_a[1] = 32'hF000_0000; v_b[1] = 32'h0000_000F; v_r[1] = 32'hF000_000F;
    v_op[2] = 3'd4; v_a[2] = 32'hFFFF_0000; v_b[2] = 32'h0F0F_0F0F; v_r[2] = 32'hF0F0_0F0F;
    v_op[3] = 3'd5; v_a[3] = 32'h0000_0001; v_b[3] = 32'h0000_0023; v_r[3] = 32'h0000_0008;
    v_op[4] = 3'd6; v_a[4] = 32'h8000_0000; v_b[4] = 32'h0000_001F; v_r[4] = 32'h0000_0001;
    v_op[5] = 3'd7; v_a[5] = 32'h0000_0001; v_b[5] = 32'hFFFF_FFFF; v_r[5] = 32'h0000_0000;
    v_op[6] = 3'd7; v_a[6] = 32'h8000_0000; v_b[6] = 32'h0000_0001; v_r[6] = 32'h0000_0001;
  end

  initial begin
    n_checks = 0;
    n_errors = 0;
    clear_inputs();
    rst_n = 1'b0;
    #2;
    check("rst_fu_ready", 32'(fu_ready), 32'h7);
    check("rst_cmp_valid", 32'(cmp_valid), 32'h0);
    check("rst_mem_req", 32'(mem_req), 32'h0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_cmp_data", cmp_data, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("idle_fu_ready", 32'(fu_ready), 32'h7);
    check("idle_cmp_valid", 32'(cmp_valid), 32'h0);

    // ALU0 ADD with wrap-around
    iss_valid = 3'b001; iss_op_0 = 3'd0; iss_a_0 = 32'hFFFF_FFFF; iss_b_0 = 32'd2;
    iss_rd_0 = 6'd5; iss_rob_0 = 6'd3;
    tick(); clear_inputs();
    check("add_valid", 32'(cmp_valid), 32'h1);
    check("add_data", cmp_data, 32'h1);
    check("add_rd", 32'(cmp_rd), 32'd5);
    check("add_rob", 32'(cmp_rob), 32'd3);
    check("add_we", 32'(cmp_we), 32'h1);
    check("add_ready", 32'(fu_ready), 32'h7);
    tick();
    check("add_drained", 32'(cmp_valid), 32'h0);

    // Dual ALU issue: ALU0 wins, ALU1 held one cycle
    iss_valid = 3'b011;
    iss_op_0 = 3'd1; iss_a_0 = 32'd5; iss_b_0 = 32'd7; iss_rd_0 = 6'd7; iss_rob_0 = 6'd4;
    iss_op_1 = 3'd7; iss_a_1 = 32'hFFFF_FFFF; iss_b_1 = 32'd1; iss_rd_1 = 6'd8; iss_rob_1 = 6'd5;
    tick(); clear_inputs();
    check("dual0_data", cmp_data, 32'hFFFF_FFFE);
    check("dual0_rd", 32'(cmp_rd), 32'd7);
    check("dual0_ready", 32'(fu_ready), 32'h5);
    tick();
    check("dual1_valid", 32'(cmp_valid), 32'h1);
    check("dual1_data", cmp_data, 32'h1);
    check("dual1_rob", 32'(cmp_rob), 32'd5);
    check("dual1_ready", 32'(fu_ready), 32'h7);
    tick();
    check("dual_drained", 32'(cmp_valid), 32'h0);

    // ALU1 op table
    for (int i = 0; i < 7; i++) begin
      iss_valid = 3'b010; iss_op_1 = v_op[i]; iss_a_1 = v_a[i]; iss_b_1 = v_b[i];
      iss_rd_1 = 6'(i + 20); iss_rob_1 = 6'(i + 30);
      tick(); clear_inputs();
      check($sformatf("alu1_op%0d_data", i), cmp_data, v_r[i]);
      check($sformatf("alu1_op%0d_rd", i), 32'(cmp_rd), 32'(i + 20));
    end
    tick();

    // Load with delayed grant; MEM beats a pending ALU0 result
    iss_valid = 3'b100; iss_op_2 = 3'd0; iss_a_2 = 32'h100; iss_b_2 = 32'h10;
    iss_rd_2 = 6'd9; iss_rob_2 = 6'd6;
    tick(); clear_inputs();
    check("ld_req", 32'(mem_req), 32'h1);
    check("ld_addr", mem_addr, 32'h110);
    check("ld_we", 32'(mem_we), 32'h0);
    check("ld_ready", 32'(fu_ready), 32'h3);
    tick();
    check("ld_req_hold1", 32'(mem_req), 32'h1);
    check("ld_addr_hold1", mem_addr, 32'h110);
    tick();
    check("ld_req_hold2", 32'(mem_req), 32'h1);
    check("ld_addr_hold2", mem_addr, 32'h110);
    mem_gnt = 1'b1;
    tick(); clear_inputs();
    check("ld_wait_req", 32'(mem_req), 32'h0);
    check("ld_wait_cmp", 32'(cmp_valid), 32'h0);
    mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    iss_valid = 3'b001; iss_op_0 = 3'd0; iss_a_0 = 32'd1; iss_b_0 = 32'd1;
    iss_rd_0 = 6'd10; iss_rob_0 = 6'd7;
    tick(); clear_inputs();
    check("ld_cmp_valid", 32'(cmp_valid), 32'h1);
    check("ld_cmp_we", 32'(cmp_we), 32'h1);
    check("ld_cmp_data", cmp_data, 32'hDEAD_BEEF);
    check("ld_cmp_rd", 32'(cmp_rd), 32'd9);
    check("ld_cmp_rob", 32'(cmp_rob), 32'd6);
    check("ld_prio_ready", 32'(fu_ready), 32'h2);
    tick();
    check("ld_alu0_after", cmp_data, 32'h2);
    check("ld_alu0_rd", 32'(cmp_rd), 32'd10);
    check("ld_after_ready", 32'(fu_ready), 32'h7);
    tick();
    check("ld_drained", 32'(cmp_valid), 32'h0);

    // Store; re-issue while busy must be ignored
    iss_valid = 3'b100; iss_op_2 = 3'd1; iss_a_2 = 32'h200; iss_b_2 = 32'h4;
    iss_sd_2 = 32'hCAFE_F00D; iss_rd_2 = 6'd11; iss_rob_2 = 6'd8;
    tick(); clear_inputs();
    check("st_req", 32'(mem_req), 32'h1);
    check("st_we", 32'(mem_we), 32'h1);
    check("st_addr", mem_addr, 32'h204);
    check("st_wdata", mem_wdata, 32'hCAFE_F00D);
    check("st_ready", 32'(fu_ready), 32'h3);
    mem_gnt = 1'b1;
    iss_valid = 3'b100; iss_op_2 = 3'd0; iss_a_2 = 32'h0; iss_b_2 = 32'h0; iss_rd_2 = 6'd12;
    tick(); clear_inputs();
    check("st_busy_addr", mem_addr, 32'h204);
    check("st_busy_we", 32'(mem_we), 32'h1);
    check("st_busy_ready", 32'(fu_ready), 32'h3);
    mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678;
    tick(); clear_inputs();
    check("st_cmp_valid", 32'(cmp_valid), 32'h1);
    check("st_cmp_we", 32'(cmp_we), 32'h0);
    check("st_cmp_data", cmp_data, 32'h0);
    check("st_cmp_rob", 32'(cmp_rob), 32'd8);
    check("st_done_ready", 32'(fu_ready), 32'h3);
    tick();
    check("st_drained", 32'(cmp_valid), 32'h0);
    check("st_idle_ready", 32'(fu_ready), 32'h7);
    check("st_no_reissue", 32'(mem_req), 32'h0);

    // Reset while waiting for rvalid abandons the load
    iss_valid = 3'b100; iss_op_2 = 3'd0; iss_a_2 = 32'h300; iss_rd_2 = 6'd13; iss_rob_2 = 6'd9;
    tick(); clear_inputs();
    mem_gnt = 1'b1;
    tick(); clear_inputs();
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_ready", 32'(fu_ready), 32'h7);
    check("mid_rst_req", 32'(mem_req), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    mem_rvalid = 1'b1; mem_rdata = 32'h0000_0BAD;
    tick(); clear_inputs();
    check("late_rvalid_cmp", 32'(cmp_valid), 32'h0);
    check("late_rvalid_ready", 32'(fu_ready), 32'h7);
    tick();
    check("late_rvalid_cmp2", 32'(cmp_valid), 32'h0);
    check("late_rvalid_req", 32'(mem_req), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/fu_bank.md
# fu_bank

Execution-side responder for the reservation station issue interface. Accepts up to three issued instructions per cycle (ALU0, ALU1, MEM), executes them, reports per-unit readiness back to the station's `fu_in`, and drives a single completion/wakeup broadcast to the station and ROB. MEM traffic goes through a req/gnt/rvalid memory port.

## Interface
Parameters:
- `PREG_WIDTH`, 6: physical register tag width
- `ROB_WIDTH`, 6: ROB index width

Ports (`*_0/_1/_2` = ALU0/ALU1/MEM, matching station FU codes 0/1/2):
- `clk` input 1: single clock, rising edge
- `rst_n` input 1: reset, asynchronous, active-low
- `iss_valid` input 3: per-unit issue strobe
- `iss_op_0/_1/_2` input 3 each: ALU op (0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SLT); MEM uses bit0 (0 load, 1 store)
- `iss_a_0/_1/_2`, `iss_b_0/_1/_2` input 32 each: operands (MEM: a = base, b = imm)
- `iss_sd_2` input 32: store data
- `iss_rd_0/_1/_2` input PREG_WIDTH each: destination tag
- `iss_rob_0/_1/_2` input ROB_WIDTH each: ROB index
- `fu_ready` output 3: unit can accept issue this cycle (to station `fu_in`)
- `mem_req` output 1; `mem_we` output 1; `mem_addr` output 32; `mem_wdata` output 32
- `mem_gnt` input 1: request accepted this cycle
- `mem_rvalid` input 1; `mem_rdata` input 32: load data / store acknowledge
- `cmp_valid` output 1: completion broadcast
- `cmp_we` output 1: broadcast writes `cmp_rd` (0 for stores)
- `cmp_rd` output PREG_WIDTH; `cmp_rob` output ROB_WIDTH; `cmp_data` output 32

## Operation
- Each ALU has one result register (valid, rd, rob, data). Issue computes the result combinationally and loads the register at the next edge.
- ALU arithmetic is 32-bit, wrap-around. Shifts use `b[4:0]`. SLT is a signed compare producing 0/1.
- MEM FSM states:
  - IDLE: on issue, latch addr = a+b (wrap), we, wdata, rd, rob, then go to REQ.
  - REQ: `mem_req`=1; on `mem_gnt`, go to WAIT.
  - WAIT: on `mem_rvalid`, latch `mem_rdata` (load) and go to DONE.
  - DONE: hold until broadcast, then go to IDLE.
- Completion arbitration is one broadcast per cycle, fixed priority MEM(DONE) > ALU0 > ALU1. Losers hold their result unchanged.
- `fu_ready[i]`:
  - ALU: result register empty, or being broadcast this cycle (same-cycle drain and refill is allowed).
  - MEM: 1 only in IDLE.
- Issue to a unit with `fu_ready[i]`=0 is ignored. No state changes.
- Store broadcast: `cmp_we`=0, `cmp_data`=0, `cmp_rob` valid.
- `mem_rvalid` outside WAIT is ignored.

## Timing
- Reset (async assert, sync-safe deassert):
  - All result valids = 0 and MEM FSM = IDLE.
  - `fu_ready`=3'b111, `mem_req`=0, `cmp_valid`=0, and all data outputs = 0.
- ALU latency: issue in cycle N, broadcast earliest in N+1.
- MEM latency: issue in N, `mem_req` high from N+1. With gnt in N+1 and rvalid in N+2, DONE is reached at N+3, which is the earliest broadcast.
- `mem_addr`/`mem_we`/`mem_wdata` are stable while `mem_req`=1.
- All broadcast outputs are registered-state driven (combinational mux of held registers only). There is no input→output combinational path except `fu_ready` ← broadcast select.
- Reset mid-transaction abandons the MEM operation. An outstanding `mem_rvalid` after reset is ignored (FSM is in IDLE).

## Structure
- Shared package: ALU op encodings, FU index constants (ALU0=0, ALU1=1, MEM=2), MEM FSM state enum, completion bundle typedef.
- Sub-module `fu_alu` (combinational op decode + result), instantiated twice. MEM FSM and arbiter stay in `fu_bank`.

## Test plan
- Reset then idle → `fu_ready`=111, `cmp_valid`=0, `mem_req`=0.
- Issue ALU0 ADD 0xFFFFFFFF+2, rd=5, rob=3 → next cycle `cmp_valid`=1, `cmp_data`=1, rd=5, rob=3, `fu_ready[0]`=1.
- Issue ALU0 and ALU1 same cycle (SUB 5-7, SLT -1<1) → cycle N+1 broadcasts ALU0 0xFFFFFFFE with `fu_ready[1]`=0; N+2 broadcasts ALU1 1.
- Load base 0x100 imm 0x10, gnt delayed 2 cycles, rvalid 0xDEADBEEF → `mem_addr`=0x110 held while req; broadcast data 0xDEADBEEF with `cmp_we`=1. MEM beats a pending ALU0 result in the same cycle.
- Store → `mem_we`=1, broadcast `cmp_we`=0, `fu_ready[2]` low from issue until broadcast. A re-issue to MEM while busy is ignored.
- Assert `rst_n`=0 in WAIT, then send `mem_rvalid` after release → no broadcast, `fu_ready`=111.
